// File: rtl/hazard_pkg.sv
// Shared opcodes, scoreboard entry type and the source/destination usage decoder
// for the OTTER decode-stage hazard unit.
package hazard_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
    } dec_use_t;

    function automatic dec_use_t decode_use(input logic [31:0] ir);
        dec_use_t   u;
        logic [6:0] op;
        op          = ir[6:0];
        u.uses_rs1  = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        u.uses_rs2  = (op == OP_BRANCH || op == OP_STORE || op == OP_OP);
        u.writes_rd = !(op == OP_BRANCH || op == OP_STORE) && (ir[11:7] != 5'd0);
        u.is_load   = (op == OP_LOAD);
        return u;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the OTTER decode stage and the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 32
);
    localparam int FWD_W = $clog2(NUM_STAGES + 1);

    logic              dec_valid;
    logic [31:0]       dec_ir;
    logic              flush;
    logic              stall;
    logic              bubble;
    logic [FWD_W-1:0]  fwd_rs1;
    logic [FWD_W-1:0]  fwd_rs2;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output dec_valid, dec_ir, flush,
        input  stall, bubble, fwd_rs1, fwd_rs2, stall_cycles
    );

    modport slave (
        input  dec_valid, dec_ir, flush,
        output stall, bubble, fwd_rs1, fwd_rs2, stall_cycles
    );

endinterface

// File: rtl/hazard_match.sv
// Combinational compare of one source register against the in-flight shadow;
// reports a hit, the youngest matching stage and whether that entry is a load.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES       = 3,
    parameter int WB_WRITE_THROUGH = 1
) (
    input  logic [4:0]                          src,
    input  logic                                src_used,
    input  sb_entry_t [NUM_STAGES-1:0]          shadow,
    output logic                                hit,
    output logic [$clog2(NUM_STAGES + 1)-1:0]   idx,
    output logic                                hit_load
);
    localparam int IDX_W   = $clog2(NUM_STAGES + 1);
    localparam int LAST_HZ = (WB_WRITE_THROUGH != 0) ? NUM_STAGES - 2 : NUM_STAGES - 1;

    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        hit_load = 1'b0;
        // Scan oldest to youngest so the youngest match is the one left standing
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (i <= LAST_HZ && src_used && src != 5'd0 &&
                shadow[i].valid && shadow[i].rd == src) begin
                hit      = 1'b1;
                idx      = IDX_W'(i);
                hit_load = shadow[i].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage data-hazard scoreboard: shadow of in-flight destinations, stall/bubble
// generation and stall-cycle counter. Define HZD_FORWARDING_EN for forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES       = 3,
    parameter int WB_WRITE_THROUGH = 1,
    parameter int CNT_W            = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    hazard_scoreboard_if.slave hz
);
    localparam int FWD_W = $clog2(NUM_STAGES + 1);

    sb_entry_t [NUM_STAGES-1:0] shadow;
    sb_entry_t                  new_entry;
    dec_use_t                   use_d;
    logic                       issue;
    logic                       stall_c;
    logic                       hit_rs1, hit_rs2;
    logic                       load_rs1, load_rs2;
    logic [FWD_W-1:0]           idx_rs1, idx_rs2;
    logic [FWD_W-1:0]           fwd_rs1_c, fwd_rs2_c;
    logic [CNT_W-1:0]           cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign use_d = decode_use(hz.dec_ir);

    hazard_match #(
        .NUM_STAGES       (NUM_STAGES),
        .WB_WRITE_THROUGH (WB_WRITE_THROUGH)
    ) u_match_rs1 (
        .src      (hz.dec_ir[19:15]),
        .src_used (use_d.uses_rs1),
        .shadow   (shadow),
        .hit      (hit_rs1),
        .idx      (idx_rs1),
        .hit_load (load_rs1)
    );

    hazard_match #(
        .NUM_STAGES       (NUM_STAGES),
        .WB_WRITE_THROUGH (WB_WRITE_THROUGH)
    ) u_match_rs2 (
        .src      (hz.dec_ir[24:20]),
        .src_used (use_d.uses_rs2),
        .shadow   (shadow),
        .hit      (hit_rs2),
        .idx      (idx_rs2),
        .hit_load (load_rs2)
    );

`ifdef HZD_FORWARDING_EN
    logic load_use;

    // Only a load still in EX cannot be forwarded in time
    assign load_use  = (hit_rs1 && idx_rs1 == '0 && load_rs1) ||
                       (hit_rs2 && idx_rs2 == '0 && load_rs2);
    assign stall_c   = hz.dec_valid && !hz.flush && load_use;
    assign fwd_rs1_c = (stall_c || !hit_rs1) ? '0 : idx_rs1 + FWD_W'(1);
    assign fwd_rs2_c = (stall_c || !hit_rs2) ? '0 : idx_rs2 + FWD_W'(1);
`else
    logic unused_match;

    assign unused_match = ^{idx_rs1, idx_rs2, load_rs1, load_rs2};
    assign stall_c      = hz.dec_valid && !hz.flush && (hit_rs1 || hit_rs2);
    assign fwd_rs1_c    = '0;
    assign fwd_rs2_c    = '0;
`endif

    assign issue = hz.dec_valid && !stall_c && !hz.flush;

    always_comb begin
        new_entry = '0;
        if (issue) begin
            new_entry.valid   = use_d.writes_rd;
            new_entry.rd      = hz.dec_ir[11:7];
            new_entry.is_load = use_d.is_load;
        end
    end

    // Shadow shift EX -> WB and stall-cycle counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow <= '0;
            cnt_q  <= '0;
        end else begin
            shadow[0] <= new_entry;
            for (int i = 1; i < NUM_STAGES; i++) begin
                shadow[i] <= shadow[i-1];
            end
            if (stall_c) begin
                cnt_q <= sat_inc(cnt_q);
            end
        end
    end

    assign hz.stall        = stall_c;
    assign hz.bubble       = stall_c || hz.flush;
    assign hz.fwd_rs1      = fwd_rs1_c;
    assign hz.fwd_rs2      = fwd_rs2_c;
    assign hz.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NUM_STAGES=3, write-through WB, 4-bit counter);
// expectations follow the build selected by HZD_FORWARDING_EN.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_scoreboard_if #(.NUM_STAGES(3), .CNT_W(4)) hz ();

    hazard_scoreboard #(
        .NUM_STAGES       (3),
        .WB_WRITE_THROUGH (1),
        .CNT_W            (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .hz    (hz)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        logic [11:0] i12;
        i12 = 12'(imm);
        return {i12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OP_OP};
    endfunction

    function automatic logic [31:0] enc_lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), OP_LOAD};
    endfunction

    function automatic logic [31:0] enc_sw(input int rs2, input int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, OP_STORE};
    endfunction

    function automatic logic [31:0] enc_lui(input int rd, input int imm20);
        return {20'(imm20), 5'(rd), OP_LUI};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic f);
        hz.dec_valid = v;
        hz.dec_ir    = ir;
        hz.flush     = f;
        #1;
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        step();
        step();
        RST_N = 1'b1;
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        step();
        step();
        check("rst_stall",  32'(hz.stall), 32'd0);
        check("rst_bubble", 32'(hz.bubble), 32'd0);
        check("rst_fwd1",   32'(hz.fwd_rs1), 32'd0);
        check("rst_fwd2",   32'(hz.fwd_rs2), 32'd0);
        check("rst_cnt",    32'(hz.stall_cycles), 32'd0);
        RST_N = 1'b1;
        #1;

        // addi x5 -> add x6,x5,x7
        apply_reset();
        drive(1'b1, enc_addi(5, 0, 1), 1'b0);
        check("prod_stall", 32'(hz.stall), 32'd0);
        step();
        drive(1'b1, enc_add(6, 5, 7), 1'b0);
`ifdef HZD_FORWARDING_EN
        check("fw_ex_stall", 32'(hz.stall), 32'd0);
        check("fw_ex_fwd1",  32'(hz.fwd_rs1), 32'd1);
        check("fw_ex_fwd2",  32'(hz.fwd_rs2), 32'd0);
        step();
        drive(1'b1, enc_addi(5, 0, 1), 1'b0);
        step();
        drive(1'b1, enc_addi(0, 0, 0), 1'b0);
        step();
        drive(1'b1, enc_add(6, 5, 5), 1'b0);
        check("fw_mem_fwd1", 32'(hz.fwd_rs1), 32'd2);
        check("fw_mem_fwd2", 32'(hz.fwd_rs2), 32'd2);
        check("fw_mem_stall", 32'(hz.stall), 32'd0);

        apply_reset();
        drive(1'b1, enc_lw(5, 0), 1'b0);
        step();
        drive(1'b1, enc_add(6, 5, 0), 1'b0);
        check("lu_stall",  32'(hz.stall), 32'd1);
        check("lu_bubble", 32'(hz.bubble), 32'd1);
        check("lu_fwd1",   32'(hz.fwd_rs1), 32'd0);
        step();
        check("lu_rel_stall", 32'(hz.stall), 32'd0);
        check("lu_rel_fwd1",  32'(hz.fwd_rs1), 32'd2);
        check("lu_rel_fwd2",  32'(hz.fwd_rs2), 32'd0);
        check("lu_cnt",       32'(hz.stall_cycles), 32'd1);

        apply_reset();
        drive(1'b1, enc_addi(5, 0, 1), 1'b0);
        step();
        drive(1'b1, enc_addi(5, 0, 2), 1'b0);
        step();
        drive(1'b1, enc_add(6, 5, 0), 1'b0);
        check("young_fwd1", 32'(hz.fwd_rs1), 32'd1);
`else
        check("dep_stall0",  32'(hz.stall), 32'd1);
        check("dep_bubble0", 32'(hz.bubble), 32'd1);
        step();
        check("dep_stall1",  32'(hz.stall), 32'd1);
        check("dep_bubble1", 32'(hz.bubble), 32'd1);
        step();
        check("dep_release", 32'(hz.stall), 32'd0);
        check("dep_bub_rel", 32'(hz.bubble), 32'd0);
        check("dep_cnt",     32'(hz.stall_cycles), 32'd2);
        check("dep_fwd1",    32'(hz.fwd_rs1), 32'd0);
`endif

        // x0 producer and x0 consumer never hazard
        apply_reset();
        drive(1'b1, enc_addi(0, 1, 1), 1'b0);
        step();
        drive(1'b1, enc_add(6, 0, 0), 1'b0);
        check("x0_stall", 32'(hz.stall), 32'd0);
        check("x0_fwd1",  32'(hz.fwd_rs1), 32'd0);
        check("x0_fwd2",  32'(hz.fwd_rs2), 32'd0);

        // lui whose rs1 field happens to equal x5 is not a consumer
        apply_reset();
        drive(1'b1, enc_addi(5, 0, 1), 1'b0);
        step();
        drive(1'b1, enc_lui(5, 32'h28), 1'b0);
        check("lui_stall", 32'(hz.stall), 32'd0);
        check("lui_fwd1",  32'(hz.fwd_rs1), 32'd0);

        // store data source rs2
        apply_reset();
        drive(1'b1, enc_addi(5, 0, 1), 1'b0);
        step();
        drive(1'b1, enc_sw(5, 6), 1'b0);
`ifdef HZD_FORWARDING_EN
        check("sw_stall", 32'(hz.stall), 32'd0);
        check("sw_fwd2",  32'(hz.fwd_rs2), 32'd1);
        check("sw_fwd1",  32'(hz.fwd_rs1), 32'd0);
`else
        check("sw_stall", 32'(hz.stall), 32'd1);
`endif

        // reset asserted while stalled on a load
        apply_reset();
        drive(1'b1, enc_lw(5, 0), 1'b0);
        step();
        drive(1'b1, enc_add(6, 5, 7), 1'b0);
        step();
        check("mr_cnt_pre", 32'(hz.stall_cycles), 32'd1);
        drive(1'b1, enc_lw(9, 0), 1'b0);
        step();
        drive(1'b1, enc_add(6, 9, 7), 1'b0);
        check("mr_stall_pre", 32'(hz.stall), 32'd1);
        RST_N = 1'b0;
        #1;
        check("mr_stall_rst",  32'(hz.stall), 32'd0);
        check("mr_bubble_rst", 32'(hz.bubble), 32'd0);
        check("mr_cnt_rst",    32'(hz.stall_cycles), 32'd0);
        RST_N = 1'b1;
        #1;
        check("mr_stall_post", 32'(hz.stall), 32'd0);
        check("mr_fwd1_post",  32'(hz.fwd_rs1), 32'd0);

        // flush beats stall and squashes the decode instruction
        apply_reset();
        drive(1'b1, enc_lw(5, 0), 1'b0);
        step();
        drive(1'b1, enc_add(6, 5, 7), 1'b0);
        check("fl_pre_stall", 32'(hz.stall), 32'd1);
        drive(1'b1, enc_add(6, 5, 7), 1'b1);
        check("fl_stall",  32'(hz.stall), 32'd0);
        check("fl_bubble", 32'(hz.bubble), 32'd1);
        step();
        check("fl_cnt", 32'(hz.stall_cycles), 32'd0);
        drive(1'b1, enc_add(1, 6, 0), 1'b0);
        check("fl_squashed_stall", 32'(hz.stall), 32'd0);
        check("fl_squashed_fwd1",  32'(hz.fwd_rs1), 32'd0);

        // self-dependent load chain drives the counter into saturation
        apply_reset();
        drive(1'b1, enc_lw(5, 5), 1'b0);
        repeat (6) step();
`ifdef HZD_FORWARDING_EN
        check("sat_cnt6", 32'(hz.stall_cycles), 32'd3);
`else
        check("sat_cnt6", 32'(hz.stall_cycles), 32'd4);
`endif
        repeat (34) step();
        check("sat_cnt", 32'(hz.stall_cycles), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
